priority_scan_encoder: RTL and testbench
========================================

Name: priority_scan_encoder

Overview:
Parametrised sequential priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then emits the index of every set bit, one per output handshake, in priority order, and clears each bit as it is consumed. It serves as the next-generation encoder for request-vector sources where every request must be serviced, not only the highest. It sits between a request collector and a per-index servicing stage.

Parameters:
WIDTH, 8, request vector width; legal range WIDTH >= 2.
MSB_FIRST, 1, priority order: 1 = highest index wins, 0 = lowest index wins.
IDX_W, $clog2(WIDTH), width of the index output; derived, not overridden.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; discards pending vector
in_valid  input  1  in_vec valid
in_ready  output  1  block can accept a vector
in_vec  input  WIDTH  request vector
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts out_idx
out_idx  output  IDX_W  index of current highest-priority pending bit
out_last  output  1  out_idx is the final pending bit of the vector
err_empty  output  1  one-cycle pulse: an all-zero vector was accepted
busy  output  1  scan in progress

Behaviour:
- State and registers:
  - States: IDLE, SCAN.
  - Registers: state, pending[WIDTH-1:0], err_empty.
- Reset (rst_n low, asynchronous):
  - state = IDLE, pending = 0, err_empty = 0.
  - Hence out_valid = 0, out_idx = 0, out_last = 0, busy = 0, in_ready = 1.
- Combinational outputs:
  - in_ready = (state == IDLE).
  - busy = (state == SCAN).
  - out_valid = (state == SCAN).
  - out_idx is the priority encode of pending per MSB_FIRST. It is forced to 0 when out_valid = 0.
  - out_last = out_valid and pending has exactly one bit set.
- IDLE:
  - Accept when in_valid and in_ready.
  - Nonzero in_vec: pending <= in_vec, go to SCAN.
  - Zero in_vec: remain in IDLE, err_empty = 1 for exactly the next cycle, no output handshake.
- Latency: first out_valid is asserted the cycle after acceptance.
- SCAN:
  - On out_valid and out_ready: clear bit out_idx in pending.
  - If out_last was 1, go to IDLE and in_ready returns the following cycle.
  - Otherwise stay in SCAN; the next index is presented the following cycle.
  - Throughput is one index per cycle under continuous out_ready.
- Backpressure: while out_valid and not out_ready, pending is unchanged, so out_idx and out_last hold stable.
- No overlap: in_ready = 0 throughout SCAN, including the final-handshake cycle. in_vec is ignored then.
- flush:
  - Flush has priority over every other event in the same cycle.
  - Next state is IDLE and pending is cleared.
  - An in-flight output handshake in the flush cycle counts as completed by the consumer, but it has no further effect.
  - Flush in IDLE blocks that cycle's acceptance; err_empty is not raised.
- err_empty: cleared every cycle in which no zero-vector acceptance occurs.
- Reset mid-SCAN: immediate return to the reset values above; the pending vector is lost.
- Index width: bits index 0..WIDTH-1. For non-power-of-2 WIDTH, out_idx never exceeds WIDTH-1.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, accept in_vec=8'b1010_0101, out_ready=1 -> out_idx 7,5,2,0 on four consecutive cycles; out_last=1 only with idx 0; in_ready=1 on the cycle after the last handshake.
2. Same vector, MSB_FIRST=0 -> out_idx 0,2,5,7; out_last with 7. Then hold out_ready=0 for 3 cycles during idx 2 -> idx 2 stable, pending unchanged, resumes 5,7.
3. WIDTH=4, MSB_FIRST=1: for each of the 15 nonzero vectors, the first out_idx equals the 4:2 highest-set-bit code (e.g. 4'b0011 -> 1, 4'b0101 -> 2, 4'b1xxx -> 3); in_vec=0 -> err_empty single-cycle pulse, out_valid stays 0.
4. Flush: accept 8'hFF, consume idx 7 and 6, assert flush together with out_ready -> next cycle IDLE, out_valid=0, pending=0. Then accept 8'h01 -> single idx 0 with out_last.
5. Reset mid-scan: accept 8'hF0, drop rst_n asynchronously between edges after one handshake -> outputs go to reset values immediately; after release, in_ready=1 and no stale indices emerge.
6. WIDTH=5, MSB_FIRST=1: in_vec=5'b10001 -> idx 4,0; in_valid held high during SCAN with new data -> ignored; accepted only once back in IDLE.

Source files
------------

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: latches a request vector, then emits the index
// of every set bit in priority order, one per output handshake.
module priority_scan_encoder #(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             err_empty,
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] enc;
  logic [WIDTH-1:0] clr_mask;
  logic             one_left;

  // Later matches overwrite earlier ones, so the scan direction sets priority.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (pending[i]) enc = IDX_W'(i);
      end else begin
        if (pending[WIDTH-1-i]) enc = IDX_W'(WIDTH-1-i);
      end
    end
  end

  assign clr_mask  = WIDTH'(1) << enc;
  assign one_left  = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SCAN);
  assign out_valid = (state == SCAN);
  assign out_idx   = out_valid ? enc : '0;
  assign out_last  = out_valid && one_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      err_empty <= 1'b0;
    end else begin
      err_empty <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              if (in_vec != '0) begin
                pending <= in_vec;
                state   <= SCAN;
              end else begin
                err_empty <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (out_ready) begin
              pending <= pending & ~clr_mask;
              if (out_last) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: four configurations share one stimulus
// stream; each has a queue-based reference model checked every cycle.
module tb_priority_scan_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = '0;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // cfg 0: W8 msb-first, 1: W8 lsb-first, 2: W4 msb-first, 3: W5 msb-first
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W  = (g < 2) ? 8 : ((g == 2) ? 4 : 5);
    localparam bit M  = (g != 1);
    localparam int IW = $clog2(W);

    logic          rdy, ov, last, err, bsy;
    logic [IW-1:0] idx;

    priority_scan_encoder #(.WIDTH(W), .MSB_FIRST(M)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy), .in_vec(in_vec[W-1:0]),
      .out_valid(ov), .out_ready(out_ready), .out_idx(idx),
      .out_last(last), .err_empty(err), .busy(bsy)
    );

    // Model: the vector becomes a list of indices in service order.
    int q[$];
    bit m_err;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        m_err = 1'b0;
        if (flush) q.delete();
        else if (q.size() == 0) begin
          if (in_valid) begin
            for (int p = 0; p < W; p++) begin
              int i;
              i = M ? (W - 1 - p) : p;
              if (in_vec[i]) q.push_back(i);
            end
            if (q.size() == 0) m_err = 1'b1;
          end
        end else if (out_ready) void'(q.pop_front());
      end
    end

    always @(negedge clk) begin
      int e_idx;
      e_idx = (q.size() != 0) ? q[0] : 0;
      chk($sformatf("cfg%0d outputs{v,idx,last,rdy,busy,err}", g),
          {ov, 8'(idx), last, rdy, bsy, err},
          {q.size() != 0, 8'(e_idx), q.size() == 1, q.size() == 0,
           q.size() != 0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (u[0].rdy && u[1].rdy && u[2].rdy && u[3].rdy) break;
      step();
    end
    chk("go_idle all ready", {u[0].rdy, u[1].rdy, u[2].rdy, u[3].rdy}, 4'hF);
  endtask

  int exp_msb[4] = '{7, 5, 2, 0};
  int exp_lsb[4] = '{0, 2, 5, 7};
  int hs4[16]    = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

  initial begin
    #12 rst_n = 1'b1;
    step();
    chk("reset in_ready", u[0].rdy, 1);
    chk("reset out_valid", u[0].ov, 0);
    chk("reset out_idx", int'(u[0].idx), 0);
    chk("reset busy", u[0].bsy, 0);

    // 8'hA5, continuous out_ready, both priority orders
    in_vec = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("msb idx[%0d]", k), int'(u[0].idx), exp_msb[k]);
      chk($sformatf("msb last[%0d]", k), u[0].last, int'(k == 3));
      chk($sformatf("lsb idx[%0d]", k), int'(u[1].idx), exp_lsb[k]);
      chk($sformatf("lsb last[%0d]", k), u[1].last, int'(k == 3));
      step();
    end
    chk("in_ready after last msb", u[0].rdy, 1);
    chk("in_ready after last lsb", u[1].rdy, 1);
    go_idle();

    // backpressure while lsb-first instance shows idx 2
    in_vec = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    chk("bp idx0", int'(u[1].idx), 0);
    step();
    chk("bp idx2", int'(u[1].idx), 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp hold idx", int'(u[1].idx), 2);
      chk("bp hold valid", u[1].ov, 1);
      chk("bp hold pending", int'(u[1].dut.pending), 8'hA4);
    end
    out_ready = 1'b1;
    step(); chk("bp resume 5", int'(u[1].idx), 5);
    step(); chk("bp resume 7", int'(u[1].idx), 7);
    chk("bp resume last", u[1].last, 1);
    go_idle();

    // every 4-bit vector: first index is the highest set bit
    for (int v = 1; v < 16; v++) begin
      in_vec = 8'(v); in_valid = 1'b1; out_ready = 1'b0;
      step(); in_valid = 1'b0;
      chk($sformatf("w4 first idx v=%0d", v), int'(u[2].idx), hs4[v]);
      go_idle();
    end
    in_vec = 8'h00; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("zero err pulse", u[2].err, 1);
    chk("zero no valid", u[2].ov, 0);
    step();
    chk("zero err cleared", u[2].err, 0);
    chk("zero still no valid", u[2].ov, 0);

    // flush mid-scan together with a handshake
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    chk("flush idx7", int'(u[0].idx), 7);
    step();
    chk("flush idx6", int'(u[0].idx), 6);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("flush out_valid", u[0].ov, 0);
    chk("flush in_ready", u[0].rdy, 1);
    chk("flush pending", int'(u[0].dut.pending), 0);
    in_vec = 8'h01; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("post flush idx", int'(u[0].idx), 0);
    chk("post flush last", u[0].last, 1);
    chk("post flush valid", u[0].ov, 1);
    go_idle();

    // asynchronous reset between edges mid-scan
    in_vec = 8'hF0; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    chk("rst idx7", int'(u[0].idx), 7);
    step();
    chk("rst idx6", int'(u[0].idx), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", u[0].ov, 0);
    chk("async rst idx", int'(u[0].idx), 0);
    chk("async rst ready", u[0].rdy, 1);
    chk("async rst busy", u[0].bsy, 0);
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    chk("post rst ready", u[0].rdy, 1);
    chk("post rst no stale", u[0].ov, 0);

    // W5: in_valid held during scan is ignored until idle
    in_vec = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_vec = 8'h0E;
    chk("w5 idx4", int'(u[3].idx), 4);
    chk("w5 not ready", u[3].rdy, 0);
    step();
    chk("w5 idx0", int'(u[3].idx), 0);
    chk("w5 last", u[3].last, 1);
    step();
    chk("w5 back idle", u[3].rdy, 1);
    chk("w5 idle no valid", u[3].ov, 0);
    step(); in_valid = 1'b0;
    chk("w5 new vec idx3", int'(u[3].idx), 3);
    go_idle();

    // randomized traffic, checked every cycle by the models
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; #2 rst_n = 1'b1;
      end
      step();
    end
    go_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
